// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: per-channel output/OE registers, synchronised and debounced inputs, sticky edge status with IRQ.
// Zero-wait-state slave (ready_out = sel_in, no backpressure); pin -> DATA_IN is SYNC_STAGES cycles + up to 3 debounce ticks.
module gpio_bank #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 36000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      address_in,
  input  logic             sel_in,
  input  logic             read_in,
  output logic [31:0]      read_value_out,
  input  logic [3:0]       write_mask_in,
  input  logic [31:0]      write_value_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_out
);

  localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] REG_DATA_OUT = 3'd0;
  localparam logic [2:0] REG_OE       = 3'd1;
  localparam logic [2:0] REG_DATA_IN  = 3'd2;
  localparam logic [2:0] REG_SET      = 3'd3;
  localparam logic [2:0] REG_CLR      = 3'd4;
  localparam logic [2:0] REG_EDGE     = 3'd5;
  localparam logic [2:0] REG_RISE_EN  = 3'd6;
  localparam logic [2:0] REG_FALL_EN  = 3'd7;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] oe;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_status;
  logic             irq_q;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_v;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [1:0]       cnt [WIDTH];
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_q;

  logic [31:0]      lane_mask;
  logic             wr_en;
  logic [2:0]       reg_idx;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rd_dat;
  logic             unused_bits;

  assign lane_mask = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                      {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
  assign wr_en     = sel_in & (|write_mask_in);
  assign reg_idx   = address_in[4:2];
  assign wmask     = lane_mask[WIDTH-1:0];
  assign wdat      = write_value_in[WIDTH-1:0] & wmask;
  assign w1c       = (wr_en && reg_idx == REG_EDGE) ? wdat : '0;

  // Reads have no side effects, and the byte offset bits never select anything.
  assign unused_bits = ^{read_in, address_in[31:5], address_in[1:0], write_value_in, lane_mask};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      oe       <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (wr_en) begin
      case (reg_idx)
        REG_DATA_OUT: data_out <= (data_out & ~wmask) | wdat;
        REG_OE:       oe       <= (oe & ~wmask) | wdat;
        REG_SET:      data_out <= data_out | wdat;
        REG_CLR:      data_out <= data_out & ~wdat;
        REG_RISE_EN:  rise_en  <= (rise_en & ~wmask) | wdat;
        REG_FALL_EN:  fall_en  <= (fall_en & ~wmask) | wdat;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_v = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == PRESC_LAST);

  // Any tick agreeing with the current debounced level restarts the count, rejecting glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= 2'd0;
    end else if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_v[i] == deb[i]) begin
          cnt[i] <= 2'd0;
        end else if (cnt[i] == 2'd2) begin
          deb[i] <= sync_v[i];
          cnt[i] <= 2'd0;
        end else begin
          cnt[i] <= cnt[i] + 2'd1;
        end
      end
    end
  end

  assign rise = deb & ~deb_q & rise_en;
  assign fall = ~deb & deb_q & fall_en;

  // New edges take priority over a same-cycle W1C so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q       <= '0;
      edge_status <= '0;
      irq_q       <= 1'b0;
    end else begin
      deb_q       <= deb;
      edge_status <= (edge_status & ~w1c) | rise | fall;
      irq_q       <= |edge_status;
    end
  end

  always_comb begin
    rd_dat = '0;
    case (reg_idx)
      REG_DATA_OUT: rd_dat = data_out;
      REG_OE:       rd_dat = oe;
      REG_DATA_IN:  rd_dat = deb;
      REG_EDGE:     rd_dat = edge_status;
      REG_RISE_EN:  rd_dat = rise_en;
      REG_FALL_EN:  rd_dat = fall_en;
      default:      rd_dat = '0;
    endcase
  end

  assign read_value_out = sel_in ? 32'(rd_dat) : 32'd0;
  assign ready_out      = sel_in;
  assign gpio_out       = data_out;
  assign gpio_oe        = oe;
  assign irq_out        = irq_q;

endmodule
